// File: rtl/reg_bank16.sv
// Sixteen-entry architectural register bank: R0-R14 in flops, R15 mirrors the PC+8 input.
// Two read ports plus a debug port, all combinational with write-first bypass.
module reg_bank16 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   a1,
  input  logic [3:0]   a2,
  input  logic [3:0]   a3,
  input  logic         we3,
  input  logic [W-1:0] wd3,
  input  logic         link_we,
  input  logic [W-1:0] link_data,
  input  logic [W-1:0] r15,
  input  logic [3:0]   dbg_sel,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  output logic [W-1:0] dbg_out,
  output logic [7:0]   wr_count
);

  logic [W-1:0] r_regs [15];
  logic [7:0]   r_wr_count;

  logic         w_we_valid;
  logic         w_we_store;
  logic [W-1:0] w_st1;
  logic [W-1:0] w_st2;
  logic [W-1:0] w_std;

  // A writeback to R15 is dropped; the link write owns R14 when both target it.
  assign w_we_valid = we3 && (a3 != 4'd15);
  assign w_we_store = w_we_valid && !(link_we && (a3 == 4'd14));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_we_store) r_regs[a3] <= wd3;
      if (link_we)    r_regs[14] <= link_data;
      if (w_we_valid || link_we) r_wr_count <= r_wr_count + 8'd1;
    end
  end

  // Bypass is suppressed while in reset so reads show the cleared storage.
  function automatic logic [W-1:0] f_read(input logic [3:0] x, input logic [W-1:0] stored);
    logic [W-1:0] v;
    v = stored;
    if (x == 4'd15)                          v = r15;
    else if (!rst_n)                         v = '0;
    else if ((x == 4'd14) && link_we)        v = link_data;
    else if (we3 && (a3 == x))               v = wd3;
    return v;
  endfunction

  always_comb begin
    w_st1 = '0;
    w_st2 = '0;
    w_std = '0;
    if (a1 != 4'd15)      w_st1 = r_regs[a1];
    if (a2 != 4'd15)      w_st2 = r_regs[a2];
    if (dbg_sel != 4'd15) w_std = r_regs[dbg_sel];
  end

  assign rd1      = f_read(a1, w_st1);
  assign rd2      = f_read(a2, w_st2);
  assign dbg_out  = f_read(dbg_sel, w_std);
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_bank16.sv
// Directed bench for reg_bank16: expected values queued as stimulus is driven,
// popped and compared against the combinational outputs between clock edges.
module tb_reg_bank16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a1, a2, a3, dbg_sel;
  logic        we3, link_we;
  logic [31:0] wd3, link_data, r15;
  logic [31:0] rd1, rd2, dbg_out;
  logic [7:0]  wr_count;

  logic [31:0] sb [$];
  int          n_cmp;
  int          n_err;
  logic [31:0] m [15];
  logic [7:0]  mc;

  reg_bank16 #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .link_we(link_we), .link_data(link_data), .r15(r15), .dbg_sel(dbg_sel),
    .rd1(rd1), .rd2(rd2), .dbg_out(dbg_out), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Advance to 2 time units past the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; we3 = 1'b1; a3 = 4'd3; wd3 = 32'hDEADBEEF;
    link_we = 1'b0; link_data = '0; r15 = 32'h0000_0108;
    a1 = 4'd3; a2 = 4'd15; dbg_sel = 4'd3;

    // Reset held with a pending write to R3
    #2;
    push(32'h0); push(32'h108); push(32'h0); push(32'h0);
    #1;
    chk("rst_rd1", rd1); chk("rst_rd2_r15", rd2); chk("rst_dbg", dbg_out); chk("rst_cnt", {24'h0, wr_count});
    step(); step();
    push(32'h0); push(32'h0);
    #1;
    chk("rst_hold_rd1", rd1); chk("rst_hold_cnt", {24'h0, wr_count});
    we3 = 1'b0;
    rst_n = 1'b1;
    step();
    push(32'h0); push(32'h0);
    #1;
    chk("post_rst_r3", rd1); chk("post_rst_cnt", {24'h0, wr_count});

    // Write R5 with same-cycle bypass
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'h1234_5678; a1 = 4'd5;
    push(32'h1234_5678);
    #1;
    chk("wr_bypass", rd1);
    step();
    we3 = 1'b0;
    push(32'h1234_5678); push(32'h1);
    #1;
    chk("wr_stored", rd1); chk("wr_cnt", {24'h0, wr_count});

    // Writes to R15 are discarded
    we3 = 1'b1; a3 = 4'd15; wd3 = 32'hFFFF_FFFF; a2 = 4'd15; dbg_sel = 4'd15;
    push(32'h108); push(32'h108);
    #1;
    chk("r15_rd2", rd2); chk("r15_dbg", dbg_out);
    step();
    we3 = 1'b0;
    push(32'h108); push(32'h1);
    #1;
    chk("r15_rd2_after", rd2); chk("r15_cnt", {24'h0, wr_count});

    // Writeback and link both targeting R14
    we3 = 1'b1; a3 = 4'd14; wd3 = 32'hAAAA_0000; link_we = 1'b1; link_data = 32'h40; a1 = 4'd14;
    push(32'h40);
    #1;
    chk("coll_bypass", rd1);
    step();
    we3 = 1'b0; link_we = 1'b0;
    push(32'h40); push(32'h2);
    #1;
    chk("coll_stored", rd1); chk("coll_cnt", {24'h0, wr_count});

    // Dual-port independence
    a1 = 4'd5; a2 = 4'd7; we3 = 1'b1; a3 = 4'd7; wd3 = 32'h77;
    push(32'h1234_5678); push(32'h77);
    #1;
    chk("dual_rd1", rd1); chk("dual_rd2", rd2);
    step();
    we3 = 1'b0; dbg_sel = 4'd7;
    push(32'h77); push(32'h3);
    #1;
    chk("dual_dbg", dbg_out); chk("dual_cnt", {24'h0, wr_count});

    // Link and an unrelated writeback together count once
    link_we = 1'b1; link_data = 32'h80; we3 = 1'b1; a3 = 4'd2; wd3 = 32'h22; a1 = 4'd14; a2 = 4'd2;
    push(32'h80); push(32'h22);
    #1;
    chk("both_rd1", rd1); chk("both_rd2", rd2);
    step();
    link_we = 1'b0; we3 = 1'b0;
    push(32'h80); push(32'h22); push(32'h4);
    #1;
    chk("both_r14", rd1); chk("both_r2", rd2); chk("both_cnt", {24'h0, wr_count});

    // 256 writes: wraps through zero and returns to the starting count
    for (int i = 0; i < 15; i++) m[i] = 32'h0;
    m[5] = 32'h1234_5678; m[7] = 32'h77; m[14] = 32'h80; m[2] = 32'h22;
    mc = 8'd4;
    for (int i = 0; i < 256; i++) begin
      we3 = 1'b1; a3 = 4'(i % 15); wd3 = 32'hC000_0000 | 32'(i);
      step();
      m[i % 15] = 32'hC000_0000 | 32'(i);
      mc = mc + 8'd1;
      if (mc == 8'd0) begin
        push(32'h0);
        #1;
        chk("wrap_zero", {24'h0, wr_count});
      end
    end
    we3 = 1'b0;
    a1 = 4'd0; a2 = 4'd14;
    push({24'h0, mc}); push(m[0]); push(m[14]);
    #1;
    chk("wrap_cnt", {24'h0, wr_count}); chk("wrap_r0", rd1); chk("wrap_r14", rd2);

    // Asynchronous reset between edges, with a write presented
    step();
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'h5555_5555; a1 = 4'd5; a2 = 4'd15; dbg_sel = 4'd14;
    rst_n = 1'b0;
    push(32'h0); push(32'h108); push(32'h0); push(32'h0);
    #1;
    chk("async_rd1", rd1); chk("async_rd2_r15", rd2); chk("async_dbg", dbg_out); chk("async_cnt", {24'h0, wr_count});
    we3 = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    a2 = 4'd0;
    push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    #1;
    chk("async_r5", rd1); chk("async_r0", rd2); chk("async_r14", dbg_out); chk("async_cnt_after", {24'h0, wr_count});

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
